// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding read to instruction memory, single-entry instruction register.
// Latency: ack in cycle n -> ir_valid in cycle n+1; first request on the 2nd rising edge after reset release.
// Backpressure: ir_valid held until ir_ready; stall blocks new launches only. Optional halt via `HALT_DETECT_EN.
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic [7:0]  pc
`ifdef HALT_DETECT_EN
  ,
  output logic        halted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
`ifdef HALT_DETECT_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t state;

  // Goes high on the first edge after reset release; IDLE waits for it so the
  // first request lands on the second edge and any ack in that window is dropped.
  logic run;

  // A redirect wins over everything except a halted core.
  logic jump_take;

`ifdef HALT_DETECT_EN
  assign jump_take = jump_en && (state != S_HALT);
`else
  assign jump_take = jump_en;
`endif

  // Fetch FSM with all outputs registered. In FETCH, imem_req=0 marks the one-cycle
  // gap after a redirect: the request relaunches next edge and any ack seen now is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      pc        <= 8'h00;
      ir_data   <= 16'h0000;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= 8'h00;
`ifdef HALT_DETECT_EN
      halted    <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      if (jump_take) begin
        pc       <= jump_addr;
        ir_valid <= 1'b0;
        imem_req <= 1'b0;
        state    <= stall ? S_IDLE : S_FETCH;
      end else begin
        case (state)
          S_IDLE: begin
            if (run && !stall) begin
              state     <= S_FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          S_FETCH: begin
            if (!imem_req) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else if (imem_ack) begin
              ir_data  <= imem_rdata;
              ir_valid <= 1'b1;
              pc       <= pc + 8'd1;
              imem_req <= 1'b0;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (ir_ready) begin
              ir_valid <= 1'b0;
`ifdef HALT_DETECT_EN
              if (ir_data == 16'hFFFF) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else
`endif
              if (!stall) begin
                state     <= S_FETCH;
                imem_req  <= 1'b1;
                imem_addr <= pc;
              end else begin
                state <= S_IDLE;
              end
            end
          end
`ifdef HALT_DETECT_EN
          S_HALT: begin
            imem_req <= 1'b0;
          end
`endif
          default: begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random traffic against a reference model.
// Inputs change just after the falling edge; outputs are compared at the falling edge.
// The bench acts as the memory, acking requests (and occasionally idling cycles) at random.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [7:0]  pc;
  logic        halted_o;

  int total = 0;
  int bad = 0;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_data    (ir_data),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .pc         (pc)
`ifdef HALT_DETECT_EN
    ,
    .halted     (halted_o)
`endif
  );

`ifndef HALT_DETECT_EN
  assign halted_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model, described by what is observable: an instruction is waiting
  // (m_vld), a read is outstanding (m_req), a relaunch is pending after a redirect
  // (m_gap), the core has halted, or otherwise it is idle.
  logic [7:0]  m_pc;
  logic [7:0]  m_addr;
  logic [15:0] m_ir;
  logic        m_vld, m_req, m_gap, m_halted, m_started;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_addr = 8'h00; m_ir = 16'h0000;
    m_vld = 1'b0; m_req = 1'b0; m_gap = 1'b0; m_halted = 1'b0; m_started = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs presently driven.
  task automatic model_step();
    if (m_halted) begin
      // only reset leaves halt
    end else if (jump_en) begin
      m_pc  = jump_addr;
      m_vld = 1'b0;
      m_req = 1'b0;
      m_gap = !stall;
    end else if (m_vld) begin
      if (ir_ready) begin
        m_vld = 1'b0;
`ifdef HALT_DETECT_EN
        if (m_ir == 16'hFFFF) m_halted = 1'b1;
        else
`endif
        if (!stall) begin
          m_req = 1'b1;
          m_addr = m_pc;
        end
      end
    end else if (m_req) begin
      if (imem_ack) begin
        m_ir  = imem_rdata;
        m_vld = 1'b1;
        m_pc  = 8'((int'(m_pc) + 1) % 256);
        m_req = 1'b0;
      end
    end else if (m_gap) begin
      m_gap  = 1'b0;
      m_req  = 1'b1;
      m_addr = m_pc;
    end else if (m_started && !stall) begin
      m_req  = 1'b1;
      m_addr = m_pc;
    end
    m_started = 1'b1;
  endtask

  task automatic check_all();
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("ir_valid", ir_valid, m_vld);
    chk("ir_data", ir_data, m_ir);
    chk("pc", pc, m_pc);
    chk("halted", halted_o, m_halted);
  endtask

  // Called just after a falling edge: drive inputs, advance model, compare at next falling edge.
  task automatic step(input logic s, input logic j, input logic [7:0] ja,
                      input logic a, input logic [15:0] rd, input logic r);
    stall = s; jump_en = j; jump_addr = ja;
    imem_ack = a; imem_rdata = rd; ir_ready = r;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset between edges, with acks pending while it is held.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h5555;
    jump_en = 1'b0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_vld", ir_valid, 1'b0);
    chk("rst_data", ir_data, 16'h0000);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic a_r;
  logic [15:0] rd_r;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset release and first fetch: request on the second edge, ack ignored before it.
    step(0, 0, 8'h00, 1, 16'hDEAD, 0);
    chk("first_req_late", imem_req, 1'b0);
    step(0, 0, 8'h00, 0, 16'h0000, 0);
    chk("first_req_addr", imem_addr, 8'h00);
    step(0, 0, 8'h00, 1, 16'h8001, 0);
    chk("first_ir", ir_data, 16'h8001);
    chk("first_pc", pc, 8'h01);
    // Held instruction under backpressure, then consumed.
    repeat (5) step(0, 0, 8'h00, 0, 16'h0000, 0);
    step(0, 0, 8'h00, 0, 16'h0000, 1);
    chk("refetch_addr", imem_addr, 8'h01);

    // pc wrap from 8'hFF via redirect.
    step(0, 1, 8'hFF, 0, 16'h0000, 0);
    step(0, 0, 8'h00, 1, 16'h7777, 0);   // gap cycle: stale ack ignored
    step(0, 0, 8'h00, 1, 16'h0042, 0);
    chk("wrap_pc", pc, 8'h00);
    step(0, 0, 8'h00, 0, 16'h0000, 1);
    chk("wrap_addr", imem_addr, 8'h00);

    // Redirect coincident with ack: data discarded, pc not incremented.
    step(0, 1, 8'h40, 1, 16'h1234, 0);
    chk("jack_ir", ir_data, 16'h0042);
    step(0, 0, 8'h00, 0, 16'h0000, 0);
    chk("jack_addr", imem_addr, 8'h40);

    // Stall during fetch: fetch completes, then idle until stall drops.
    step(1, 0, 8'h00, 0, 16'h0000, 0);
    step(1, 0, 8'h00, 1, 16'hFFFF, 0);
    step(1, 0, 8'h00, 0, 16'h0000, 1);
    step(1, 0, 8'h00, 0, 16'h0000, 0);
    step(1, 0, 8'h00, 0, 16'h0000, 0);
    step(0, 0, 8'h00, 0, 16'h0000, 0);
    // Halted core ignores redirects (ordinary idle/fetch otherwise).
    step(0, 1, 8'h20, 0, 16'h0000, 0);
    step(0, 0, 8'h00, 0, 16'h0000, 0);
    do_reset();
    step(0, 0, 8'h00, 0, 16'h0000, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end
      a_r  = imem_req ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
      rd_r = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(4) == 0, $urandom_range(9) == 0,
           ($urandom_range(3) == 0) ? 8'($urandom_range(255, 252)) : 8'($urandom),
           a_r, rd_r, 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Single clock `clk`; reset `rst_n` is asynchronous and active-low.
REQ-002 Port list, one per line: name, direction, width, meaning.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  async active-low reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  8  instruction memory word address (= pc while imem_req=1).
- imem_ack  input  1  memory read-data-valid strobe, one cycle.
- imem_rdata  input  16  instruction word, valid when imem_ack=1.
- ir_data  output  16  instruction register, feeds the control unit.
- ir_valid  output  1  ir_data holds an unconsumed instruction.
- ir_ready  input  1  control unit accepts ir_data this cycle.
- stall  input  1  inhibit launching a new fetch.
- jump_en  input  1  redirect request, one cycle.
- jump_addr  input  8  redirect target.
- pc  output  8  address of the next instruction to fetch.
- halted  output  1  fetch halted (present only with HALT_DETECT_EN).

Function
REQ-003 FSM states: IDLE, FETCH, HOLD, HALT (HALT only with HALT_DETECT_EN); all transitions on rising clk.
REQ-004 IDLE: imem_req=0; next state FETCH if stall=0, else stay in IDLE.
REQ-005 FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack; imem_ack=0 keeps FETCH indefinitely.
REQ-006 FETCH with imem_ack=1:
- ir_data<=imem_rdata, ir_valid<=1, pc<=pc+1, next state HOLD.
- imem_req deasserts in the same cycle ir_valid rises.
- Latency: ack in cycle n -> ir_valid=1 in cycle n+1.
REQ-007 pc arithmetic is 8-bit modulo; 8'hFF+1 wraps to 8'h00 with no flag.
REQ-008 HOLD: ir_data and ir_valid held stable while ir_ready=0.
REQ-009 HOLD with ir_ready=1: ir_valid<=0; next state FETCH if stall=0, else IDLE.
REQ-010 ir_ready while ir_valid=0 is ignored.
REQ-011 stall only blocks new fetch launches; an outstanding FETCH completes normally regardless of stall.
REQ-012 jump_en=1 in any state except HALT:
- pc<=jump_addr, ir_valid<=0, next state FETCH (IDLE if stall=1).
- Takes priority over imem_ack and ir_ready in the same cycle.
REQ-013 jump_en coincident with imem_ack: imem_rdata is discarded, ir_data is unchanged, pc does not increment.
REQ-014 jump_en in FETCH without ack: imem_req is dropped for exactly one cycle, then re-asserted with the new address; a late ack for the old address in that gap cycle is ignored.
REQ-015 ir_data retains its last value when ir_valid=0.

Reset
REQ-016 rst_n=0 immediately forces, independent of clk:
- state=IDLE, pc=8'h00, ir_data=16'h0000;
- ir_valid=0, imem_req=0, imem_addr=8'h00, halted=0.
REQ-017 Reset mid-FETCH abandons the request; any ack while rst_n=0 or in the first cycle after release is ignored.
REQ-018 First imem_req asserts in the second rising edge after rst_n deasserts, given stall=0.

Configuration
REQ-019 Macro HALT_DETECT_EN:
- Defined: a fetched word 16'hFFFF loads ir_data and sets ir_valid as normal. After it is consumed (ir_ready=1), the FSM enters HALT with halted=1, imem_req=0 and pc frozen; jump_en is ignored; only rst_n exits HALT.
- Not defined: 16'hFFFF is an ordinary instruction, the HALT state and the halted port do not exist, and behaviour is identical in all other respects.

Verification
REQ-020 Reset release, stall=0, memory acks one cycle after req with 16'h8001 -> imem_addr=0, ir_data=16'h8001, ir_valid=1, pc=1.
REQ-021 ir_ready held 0 for 5 cycles after ir_valid -> ir_data constant, imem_req=0 throughout; ir_ready=1 -> next fetch at addr 1.
REQ-022 pc=8'hFF, fetch acked -> pc=8'h00, next imem_addr=8'h00.
REQ-023 jump_en=1, jump_addr=8'h40 in the same cycle as imem_ack (data 16'h1234) -> ir_data unchanged, ir_valid=0, next imem_addr=8'h40.
REQ-024 stall=1 asserted during FETCH -> fetch completes, ir_valid=1; after consumption the FSM idles until stall=0.
REQ-025 With HALT_DETECT_EN: fetch 16'hFFFF, consume -> halted=1, imem_req stays 0, jump_en ignored; rst_n pulse -> halted=0, pc=0.
